// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the UART receiver slice. Holds the
//               receive FSM state encoding, the FIFO entry layout
//               {parity_err, frame_err, data[7:0]} and a helper that packs
//               one entry.
//               Optional feature macro: UART_RX_PARITY_EN (8E1 frames).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    localparam int DATA_W         = 8;
    localparam int ENTRY_W        = 10;
    localparam int BIT_FRAME_ERR  = 8;
    localparam int BIT_PARITY_ERR = 9;
    localparam int LAST_DATA_BIT  = 7;

    function automatic logic [ENTRY_W-1:0] pack_entry(
        input logic              perr,
        input logic              ferr,
        input logic [DATA_W-1:0] data
    );
        return {perr, ferr, data};
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Receive FIFO for the UART receiver. Power-of-two storage with
//               wrapping read/write pointers and a separate occupancy count.
//               The head entry is presented combinationally (zero when
//               empty). A push into a full FIFO is dropped unless a pop
//               happens in the same cycle; a drop raises a one-cycle
//               overrun pulse on the following cycle.
// Ports       : clk, rst_n (sync, active-low)
//               push, push_data  - write side
//               pop              - remove head (ignored when empty)
//               head, empty      - read side
//               overrun          - registered drop pulse
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    output logic [ENTRY_W-1:0] head,
    output logic               empty,
    output logic               overrun
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_overrun;

    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign empty     = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = pop && !empty;
    // When full, wptr == rptr: the slot being overwritten is the head that
    // leaves in this same cycle, so push-with-pop on a full FIFO is safe.
    assign w_do_push = push && (!w_full || w_do_pop);

    assign head    = empty ? '0 : r_mem[r_rptr];
    assign overrun = r_overrun;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= push && !w_do_push;
            if (w_do_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : uart_receiver
// Description : Asynchronous serial receiver (8N1, or 8E1 when the macro
//               UART_RX_PARITY_EN is defined) with a small receive FIFO.
//               The line is double-flopped, a falling edge starts a frame,
//               each bit is sampled near its centre, and the completed byte
//               plus its error flags is pushed into uart_rx_fifo.
// Ports       : clk, rst_n (sync, active-low)
//               rx                         - serial line, idle high
//               rd_en                      - pop FIFO head
//               rd_data, frame_err,
//               parity_err, rx_valid       - FIFO head / not-empty
//               overrun                    - one-cycle drop pulse
//               busy                       - receive FSM not idle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = 4167,
    parameter int FIFO_DEPTH = 4
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun,
    output logic              busy
);

    localparam int                CNT_W    = $clog2(BAUD_DIV + 1);
    localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(BAUD_DIV / 2);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(BAUD_DIV);

    rx_state_t          r_state;
    logic               r_sync1;
    logic               r_sync2;
    logic               r_sync_prev;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_bit_idx;
    logic [DATA_W-1:0]  r_shift;
    logic               r_push;
    logic [ENTRY_W-1:0] r_entry;
`ifdef UART_RX_PARITY_EN
    logic               r_par_bit;
`endif

    logic               w_fall;
    logic               w_tick;
    logic               w_par_err;
    logic [ENTRY_W-1:0] w_head;
    logic               w_empty;

    assign w_fall = r_sync_prev && !r_sync2;
    // Sample point: the edge on which the down-counter expires, so samples
    // land exactly BAUD_DIV cycles apart after each reload.
    assign w_tick = (r_cnt == CNT_W'(1));

`ifdef UART_RX_PARITY_EN
    // Even parity: XOR over data and parity bit must be zero.
    assign w_par_err = ^{r_shift, r_par_bit};
`else
    assign w_par_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_sync_prev <= 1'b1;
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_push      <= 1'b0;
            r_entry     <= '0;
`ifdef UART_RX_PARITY_EN
            r_par_bit   <= 1'b0;
`endif
        end else begin
            r_sync1     <= rx;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;
            r_push      <= 1'b0;

            // Free-running decrement; reloads below take priority.
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_state <= ST_START;
                        r_cnt   <= CNT_HALF;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        if (!r_sync2) begin
                            r_state   <= ST_DATA;
                            r_cnt     <= CNT_FULL;
                            r_bit_idx <= '0;
                        end else begin
                            // Line back high at mid start bit: a glitch.
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        r_shift <= {r_sync2, r_shift[DATA_W-1:1]};
                        r_cnt   <= CNT_FULL;
                        if (r_bit_idx == 3'(LAST_DATA_BIT)) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= ST_PARITY;
`else
                            r_state <= ST_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
`ifdef UART_RX_PARITY_EN
                    if (w_tick) begin
                        r_par_bit <= r_sync2;
                        r_cnt     <= CNT_FULL;
                        r_state   <= ST_STOP;
                    end
`else
                    r_state <= ST_IDLE;
`endif
                end
                ST_STOP: begin
                    if (w_tick) begin
                        r_push  <= 1'b1;
                        r_entry <= pack_entry(w_par_err, ~r_sync2, r_shift);
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (r_push),
        .push_data (r_entry),
        .pop       (rd_en),
        .head      (w_head),
        .empty     (w_empty),
        .overrun   (overrun)
    );

    assign rd_data    = w_head[DATA_W-1:0];
    assign frame_err  = w_head[BIT_FRAME_ERR];
    assign parity_err = w_head[BIT_PARITY_ERR];
    assign rx_valid   = !w_empty;
    assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_receiver
// Description : Self-checking bench for uart_receiver (BAUD_DIV=16,
//               FIFO_DEPTH=4). Serial frames are generated bit by bit; a
//               queue-based model predicts FIFO contents and drops.
//               Parity scenarios follow the UART_RX_PARITY_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_receiver;

    localparam int BAUD_DIV   = 16;
    localparam int FIFO_DEPTH = 4;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int ovr_cycles = 0;
    int exp_ovr = 0;

    // Model entry: {parity_err, frame_err, data}
    logic [9:0] q[$];

    always #5 clk = ~clk;

    uart_receiver #(
        .BAUD_DIV   (BAUD_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always @(negedge clk) begin
        if (overrun === 1'b1) ovr_cycles++;
    end

    function automatic logic [9:0] model_entry(input logic [7:0] d,
                                               input logic stop_bit,
                                               input logic par_bit);
        logic perr;
        perr = PAR_EN ? ((^d) ^ par_bit) : 1'b0;
        return {perr, ~stop_bit, d};
    endfunction

    // Sends one frame and updates the model; starts and ends on a negedge.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                              input logic par_bit, input int gap);
        if (q.size() < FIFO_DEPTH) q.push_back(model_entry(d, stop_bit, par_bit));
        else exp_ovr++;
        rx = 1'b0;
        repeat (BAUD_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BAUD_DIV) @(negedge clk);
        end
        if (PAR_EN) begin
            rx = par_bit;
            repeat (BAUD_DIV) @(negedge clk);
        end
        rx = stop_bit;
        repeat (BAUD_DIV) @(negedge clk);
        rx = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    // Captures {rx_valid, parity_err, frame_err, rd_data} then pulses rd_en.
    task automatic read_head(output logic [10:0] obs);
        obs = {rx_valid, parity_err, frame_err, rd_data};
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({rx_valid, rd_data, frame_err, parity_err, overrun, busy} !== 13'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {rx_valid, rd_data, frame_err, parity_err, overrun, busy});
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({rx_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release: got %b expected 00", {rx_valid, busy});
        end
    endtask

    task automatic test_single;
        logic [10:0] obs, exp;
        logic [7:0]  d;
        int          ovr0;
        send_frame(8'h0F, 1'b1, 1'b0, BAUD_DIV);
        exp = {1'b1, q.pop_front()};
        read_head(obs);
        checks++;
        if (obs !== exp || exp !== 11'h40F) begin
            errors++;
            $display("FAIL single_0x0F: got %h expected %h", obs, exp);
        end
        checks++;
        if ({rx_valid, parity_err, frame_err, rd_data} !== 11'h0) begin
            errors++;
            $display("FAIL single_pop_empty: got %h expected 0",
                     {rx_valid, parity_err, frame_err, rd_data});
        end
        // Reads while empty must not disturb the pointers.
        ovr0 = ovr_cycles;
        read_head(obs);
        read_head(obs);
        checks++;
        if ({rx_valid, ovr_cycles - ovr0} !== {1'b0, 32'd0}) begin
            errors++;
            $display("FAIL empty_read: got valid=%b ovr=%0d expected 0 0",
                     rx_valid, ovr_cycles - ovr0);
        end
        d = 8'($urandom);
        send_frame(d, 1'b1, ^d, BAUD_DIV);
        exp = {1'b1, q.pop_front()};
        read_head(obs);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL after_empty_read: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_overrun;
        logic [10:0] obs, exp;
        logic [7:0]  bytes [5];
        int          ovr0, exp0;
        bytes[0] = 8'h3D; bytes[1] = 8'hA5; bytes[2] = 8'h00;
        bytes[3] = 8'hFF; bytes[4] = 8'h11;
        ovr0 = ovr_cycles;
        exp0 = exp_ovr;
        for (int i = 0; i < 5; i++) send_frame(bytes[i], 1'b1, ^bytes[i], BAUD_DIV);
        checks++;
        if (ovr_cycles - ovr0 !== 1 || exp_ovr - exp0 !== 1) begin
            errors++;
            $display("FAIL overrun_pulse: got %0d cycles expected 1", ovr_cycles - ovr0);
        end
        for (int i = 0; i < 4; i++) begin
            exp = {1'b1, q.pop_front()};
            read_head(obs);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL overrun_read%0d: got %h expected %h", i, obs, exp);
            end
        end
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL overrun_drained: got valid=%b expected 0", rx_valid);
        end
    endtask

    task automatic test_glitch;
        bit done;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy_high: got %b expected 1", busy);
        end
        done = 1'b0;
        for (int i = 0; i < BAUD_DIV / 2 + 3 && !done; i++) begin
            @(negedge clk);
            if (busy === 1'b0) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL glitch_busy_return: got busy=%b expected 0 within %0d cycles",
                     busy, BAUD_DIV / 2 + 3);
        end
        repeat (BAUD_DIV) @(negedge clk);
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL glitch_no_push: got valid=%b expected 0", rx_valid);
        end
    endtask

    task automatic test_frame_err;
        logic [10:0] obs, exp;
        send_frame(8'h55, 1'b0, 1'b0, BAUD_DIV);
        exp = {1'b1, q.pop_front()};
        read_head(obs);
        checks++;
        if (obs !== exp || obs[8] !== 1'b1) begin
            errors++;
            $display("FAIL frame_err_0x55: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_reset_mid;
        logic [10:0] obs, exp;
        logic [7:0]  d;
        d  = 8'hC3;
        rx = 1'b0;
        repeat (BAUD_DIV) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = d[i];
            repeat (BAUD_DIV) @(negedge clk);
        end
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (BAUD_DIV) @(negedge clk);
        checks++;
        if ({rx_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_abandon: got %b expected 00", {rx_valid, busy});
        end
        send_frame(8'h7E, 1'b1, 1'b0, BAUD_DIV);
        exp = {1'b1, q.pop_front()};
        read_head(obs);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_mid_0x7E: got %h expected %h", obs, exp);
        end
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_only_one: got valid=%b expected 0", rx_valid);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        logic [10:0] obs, exp;
        send_frame(8'h07, 1'b1, 1'b0, BAUD_DIV);
        exp = {1'b1, q.pop_front()};
        read_head(obs);
        checks++;
        if (obs !== exp || obs[9] !== 1'b1) begin
            errors++;
            $display("FAIL parity_bad: got %h expected %h", obs, exp);
        end
        send_frame(8'h07, 1'b1, 1'b1, BAUD_DIV);
        exp = {1'b1, q.pop_front()};
        read_head(obs);
        checks++;
        if (obs !== exp || obs[9] !== 1'b0) begin
            errors++;
            $display("FAIL parity_good: got %h expected %h", obs, exp);
        end
    endtask
`endif

    task automatic test_random;
        logic [10:0] obs, exp;
        logic [7:0]  d;
        logic        stop_bit, par_bit;
        int          npop, ovr0, exp0;
        ovr0 = ovr_cycles;
        exp0 = exp_ovr;
        for (int it = 0; it < 24; it++) begin
            d        = 8'($urandom);
            stop_bit = ($urandom_range(0, 3) != 0);
            par_bit  = 1'($urandom);
            send_frame(d, stop_bit, par_bit, BAUD_DIV + int'($urandom_range(0, 5)));
            npop = int'($urandom_range(0, q.size()));
            for (int k = 0; k < npop; k++) begin
                exp = {1'b1, q.pop_front()};
                read_head(obs);
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL random_it%0d_rd%0d: got %h expected %h", it, k, obs, exp);
                end
            end
        end
        while (q.size() > 0) begin
            exp = {1'b1, q.pop_front()};
            read_head(obs);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL random_drain: got %h expected %h", obs, exp);
            end
        end
        checks++;
        if (ovr_cycles - ovr0 !== exp_ovr - exp0) begin
            errors++;
            $display("FAIL random_overrun: got %0d expected %0d",
                     ovr_cycles - ovr0, exp_ovr - exp0);
        end
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL random_final_empty: got valid=%b expected 0", rx_valid);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_overrun();
        test_glitch();
        test_frame_err();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 4167, clock cycles per serial bit (minimum 8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of receive FIFO entries (power of two, minimum 2).
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port rd_en  input  1  pop the FIFO head.
REQ-007 SHALL have port rd_data  output  8  data byte at the FIFO head.
REQ-008 SHALL have port rx_valid  output  1  FIFO not empty.
REQ-009 SHALL have port frame_err  output  1  stop-bit error flag of the head entry.
REQ-010 SHALL have port parity_err  output  1  parity error flag of the head entry.
REQ-011 SHALL have port overrun  output  1  one-cycle pulse when a received byte is dropped.
REQ-012 SHALL have port busy  output  1  high while the state machine is not in IDLE.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-015 IDLE->START on a synchronized high-to-low transition; the bit counter loads BAUD_DIV/2.
REQ-016 START SHALL sample at the half-bit point: low -> DATA with the counter reloaded to BAUD_DIV; high -> IDLE (glitch rejection, no push).
REQ-017 DATA SHALL sample 8 bits LSB-first, each BAUD_DIV cycles after the previous sample, into a shift register.
REQ-018 After the 8th data bit, DATA SHALL go to PARITY when parity is compiled in, else to STOP.
REQ-019 STOP SHALL sample one bit; stop==0 sets frame_err on the entry; then go to IDLE without waiting for rx high.
REQ-020 The byte SHALL be pushed as {parity_err, frame_err, data} in the cycle after the stop sample; rx_valid is high the following cycle.
REQ-021 If the FIFO is full at push and rd_en is low, the byte SHALL be dropped and overrun pulses high for exactly one cycle.
REQ-022 A simultaneous push and pop on a full FIFO SHALL accept the push and raise no overrun.
REQ-023 rd_en while empty SHALL be ignored; pointers and outputs are unchanged.
REQ-024 rd_data, frame_err and parity_err SHALL show the head entry combinationally from FIFO storage; they are 0 when empty.
REQ-025 Read and write pointers SHALL wrap modulo FIFO_DEPTH, with a separate occupancy count for full/empty.

Reset
REQ-026 On rst_n low at a clk edge the FSM SHALL enter IDLE, the synchronizer flops SHALL go to 1, and counters, pointers and occupancy SHALL go to 0.
REQ-027 Reset SHALL force rx_valid=0, rd_data=0, frame_err=0, parity_err=0, overrun=0 and busy=0.
REQ-028 Reset mid-frame SHALL abandon the frame with no push; the next falling edge after release starts a new frame.

Configuration
REQ-029 Macro UART_RX_PARITY_EN defined: frames SHALL be 8E1, the PARITY state samples one bit, and parity_err=1 when the XOR of the 8 data bits and the parity bit is 1.
REQ-030 Macro UART_RX_PARITY_EN undefined: frames SHALL be 8N1, the PARITY state is unreachable, and the stored parity_err is 0.

Structure
REQ-031 A shared package uart_pkg SHALL hold the FSM state enum, the FIFO entry width constant (10) and the bit-index constants.
REQ-032 The FIFO SHALL be a separate sub-module uart_rx_fifo (storage, pointers, full/empty); the FSM and synchronizer stay in uart_receiver.

Verification (bench uses BAUD_DIV=16, FIFO_DEPTH=4)
REQ-033 Send 0x0F (8N1) -> rx_valid rises; rd_data=0x0F; frame_err=0; rd_en pulse -> rx_valid=0.
REQ-034 Send 0x3D, 0xA5, 0x00, 0xFF, 0x11 with no reads -> first four are read back in order; overrun pulses once during the fifth byte; 0x11 is never read.
REQ-035 rx low for 4 cycles, then high -> no push; busy returns to 0 within BAUD_DIV/2+3 cycles.
REQ-036 Send 0x55 with stop bit 0 -> rd_data=0x55 with frame_err=1.
REQ-037 rst_n low after 3 data bits of 0xC3, then a clean 0x7E -> only 0x7E is read.
REQ-038 With UART_RX_PARITY_EN, send 0x07 with parity 0 -> parity_err=1; send 0x07 with parity 1 -> parity_err=0.
